// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   state_t         - responder FSM states (IDLE, WAIT, RESP)
//   SZ_B/H/W/D      - legal transfer sizes in bytes
//   size_align_bad  - flags an illegal size or an address misaligned to it
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    // 1 when size is not 1/2/4/8, or addr is not a multiple of size.
    function automatic logic size_align_bad(input logic [3:0]  size,
                                            input logic [63:0] addr);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr[0];
            SZ_W:    bad = |addr[1:0];
            SZ_D:    bad = |addr[2:0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_store.sv
// dmem_store: byte-addressed storage array with big-endian, size-masked
// access steering.
//   clk    - clock; writes occur on its rising edge
//   wr_en  - perform a store of size bytes at addr this edge
//   addr   - byte address (already known to be in range and aligned)
//   wdata  - store data, right-justified
//   size   - transfer size in bytes (1, 2, 4 or 8)
//   rdata  - combinational load data, right-justified, zero-extended
// The byte at addr is the most-significant byte of the size-wide datum.
module dmem_store
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    input  logic [3:0]    size,
    output logic [63:0]   rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    // Bit offset inside the right-justified datum of the byte at addr+i.
    // Modulo-8 arithmetic maps size 8 onto 0, so 0-1-i still gives 7-i.
    function automatic logic [5:0] lane_base(input logic [3:0]  sz,
                                             input int unsigned i);
        logic [2:0] lane;
        lane = 3'(sz) - 3'd1 - 3'(i);
        return {lane, 3'b000};
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (i < 32'(size)) begin
                    mem[addr + AW'(i)] <= wdata[lane_base(size, i) +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < 32'(size)) begin
                rdata[lane_base(size, i) +: 8] = mem[addr + AW'(i)];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// response latency.
//   clk, reset           - clock and synchronous active-high reset
//   req_valid/req_ready  - request handshake (ready only in IDLE)
//   req_write            - 1 = store, 0 = load
//   req_addr             - byte address
//   req_wdata            - store data, right-justified
//   req_size             - transfer size in bytes (1, 2, 4, 8 legal)
//   rsp_valid/rsp_ready  - response handshake
//   rsp_rdata            - load data; 0 for stores and errors
//   rsp_err              - transfer rejected (bad size, misaligned, out of range)
// rsp_valid rises LATENCY+1 cycles after the accept cycle; the storage
// access happens on the edge that enters RESP.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW       = $clog2(DEPTH_BYTES);
    localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        enter_resp;

    logic        write_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [3:0]  size_q;

    logic        eff_write;
    logic [63:0] eff_addr;
    logic [63:0] eff_wdata;
    logic [3:0]  eff_size;
    logic        eff_err;
    logic        wr_en;
    logic [63:0] rd_data;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // With LATENCY 0 the access happens on the accept edge itself, before
    // the request registers are loaded, so IDLE steers the live inputs.
    always_comb begin
        eff_write = write_q;
        eff_addr  = addr_q;
        eff_wdata = wdata_q;
        eff_size  = size_q;
        if (state_q == IDLE) begin
            eff_write = req_write;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
            eff_size  = req_size;
        end
    end

    // Range check on 65 bits so an address near 2^64 cannot wrap into range.
    always_comb begin
        eff_err = size_align_bad(eff_size, eff_addr) ||
                  (({1'b0, eff_addr} + 65'(eff_size)) > 65'(DEPTH_BYTES));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
        end
    end

    // Reset at the RESP-entry edge abandons the transfer, store included.
    assign wr_en = enter_resp && eff_write && !eff_err && !reset;

    dmem_store #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_store (
        .clk   (clk),
        .wr_en (wr_en),
        .addr  (eff_addr[AW-1:0]),
        .wdata (eff_wdata),
        .size  (eff_size),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= eff_err;
            rsp_rdata <= (eff_write || eff_err) ? '0 : rd_data;
        end else if ((state_q == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

endmodule
